// File: rtl/sdrc_init_seq_if.sv
// SDRAM command-pin bundle produced by the power-up init sequencer.
// master = sequencer (drives the pins), slave = command mux / pad logic.
interface sdrc_init_seq_if #(
    parameter int SDR_AW = 13
);
    logic              sdr_cke;
    logic              sdr_cs_n;
    logic              sdr_ras_n;
    logic              sdr_cas_n;
    logic              sdr_we_n;
    logic [1:0]        sdr_ba;
    logic [SDR_AW-1:0] sdr_addr;
    logic              sdr_init_done;
    logic              init_busy;

    modport master (
        output sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n,
        output sdr_ba, sdr_addr, sdr_init_done, init_busy
    );

    modport slave (
        input  sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n,
        input  sdr_ba, sdr_addr, sdr_init_done, init_busy
    );
endinterface

// File: rtl/sdrc_init_seq.sv
// SDRAM power-up init sequencer: NOP wait, precharge-all, N auto-refreshes, load mode, done.
// Optional SDR_INIT_EXT_MODE_EN adds an extended mode-register load (ba=01) before DONE.
module sdrc_init_seq #(
    parameter int SDR_AW    = 13,
    parameter int PWRUP_CYC = 10000,
    parameter int AREF_NUM  = 2,
    parameter int TRFC_MIN  = 7
) (
    input  logic            sdram_clk,
    input  logic            sdram_resetn,
    input  logic            cfg_sdr_en,
    input  logic [2:0]      cfg_sdr_cas,
    input  logic [2:0]      cfg_sdr_bl,
    input  logic [3:0]      cfg_sdr_trp_d,
    input  logic [3:0]      cfg_sdr_trfc_d,
    input  logic [3:0]      cfg_sdr_tmrd_d,
    sdrc_init_seq_if.master sdr_if
);
    localparam int            PW         = $clog2(PWRUP_CYC + 1);
    localparam logic [PW-1:0] PWR_LAST   = PW'(PWRUP_CYC - 1);
    localparam logic [PW-1:0] PWR_TERM   = PW'(PWRUP_CYC);
    localparam logic [3:0]    AREF_LAST  = 4'(AREF_NUM);
    // A wait state always lasts at least one cycle, even if TRFC_MIN is 1.
    localparam logic [3:0]    TRFC_FLOOR = (TRFC_MIN > 1) ? 4'(TRFC_MIN - 1) : 4'd1;

    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_PWRUP = 4'd1;
    localparam logic [3:0] ST_PRE   = 4'd2;
    localparam logic [3:0] ST_TRP   = 4'd3;
    localparam logic [3:0] ST_AREF  = 4'd4;
    localparam logic [3:0] ST_TRFC  = 4'd5;
    localparam logic [3:0] ST_MRS   = 4'd6;
    localparam logic [3:0] ST_TMRD  = 4'd7;
    localparam logic [3:0] ST_DONE  = 4'd8;
`ifdef SDR_INIT_EXT_MODE_EN
    localparam logic [3:0] ST_EMRS  = 4'd9;
    localparam logic [3:0] ST_TEMRD = 4'd10;
`endif

    logic [3:0]        r_state;
    logic [3:0]        w_next;
    logic [PW-1:0]     r_pwr_cnt;
    logic [3:0]        r_wait_cnt;
    logic [3:0]        r_aref_cnt;

    logic [3:0]        w_trp_len;
    logic [3:0]        w_trfc_len;
    logic [3:0]        w_tmrd_len;
    logic [3:0]        w_wait_len;
    logic              w_in_wait;
    logic              w_wait_last;

    logic              w_cke;
    logic              w_cs_n;
    logic              w_ras_n;
    logic              w_cas_n;
    logic              w_we_n;
    logic [1:0]        w_ba;
    logic [SDR_AW-1:0] w_addr;
    logic              w_done;
    logic              w_busy;

    logic              r_cke;
    logic              r_cs_n;
    logic              r_ras_n;
    logic              r_cas_n;
    logic              r_we_n;
    logic [1:0]        r_ba;
    logic [SDR_AW-1:0] r_addr;
    logic              r_done;
    logic              r_busy;

    assign w_trp_len  = (cfg_sdr_trp_d == 4'd0) ? 4'd1 : cfg_sdr_trp_d;
    assign w_trfc_len = (cfg_sdr_trfc_d < TRFC_FLOOR) ? TRFC_FLOOR : cfg_sdr_trfc_d;
    assign w_tmrd_len = (cfg_sdr_tmrd_d == 4'd0) ? 4'd1 : cfg_sdr_tmrd_d;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_in_wait  = 1'b1;
        w_wait_len = 4'd1;
        case (r_state)
            ST_TRP:   w_wait_len = w_trp_len;
            ST_TRFC:  w_wait_len = w_trfc_len;
            ST_TMRD:  w_wait_len = w_tmrd_len;
`ifdef SDR_INIT_EXT_MODE_EN
            ST_TEMRD: w_wait_len = w_tmrd_len;
`endif
            default:  w_in_wait  = 1'b0;
        endcase
    end

    assign w_wait_last = w_in_wait && (r_wait_cnt == (w_wait_len - 4'd1));

    always_comb begin
        w_next = r_state;
        if (!cfg_sdr_en) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  w_next = ST_PWRUP;
                ST_PWRUP: if (r_pwr_cnt == PWR_LAST) w_next = ST_PRE;
                ST_PRE:   w_next = ST_TRP;
                ST_TRP:   if (w_wait_last) w_next = ST_AREF;
                ST_AREF:  w_next = ST_TRFC;
                ST_TRFC:  if (w_wait_last) w_next = (r_aref_cnt < AREF_LAST) ? ST_AREF : ST_MRS;
                ST_MRS:   w_next = ST_TMRD;
`ifdef SDR_INIT_EXT_MODE_EN
                ST_TMRD:  if (w_wait_last) w_next = ST_EMRS;
                ST_EMRS:  w_next = ST_TEMRD;
                ST_TEMRD: if (w_wait_last) w_next = ST_DONE;
`else
                ST_TMRD:  if (w_wait_last) w_next = ST_DONE;
`endif
                ST_DONE:  w_next = ST_DONE;
                default:  w_next = ST_IDLE;
            endcase
        end
    end

    // Pins are decoded from the next state so they line up with the registered state.
    always_comb begin
        w_cke   = 1'b1;
        w_cs_n  = 1'b0;
        w_ras_n = 1'b1;
        w_cas_n = 1'b1;
        w_we_n  = 1'b1;
        w_ba    = 2'b00;
        w_addr  = '0;
        w_done  = 1'b0;
        w_busy  = 1'b1;
        case (w_next)
            ST_IDLE: begin
                w_cke  = 1'b0;
                w_cs_n = 1'b1;
                w_busy = 1'b0;
            end
            ST_PRE: begin
                w_ras_n    = 1'b0;
                w_we_n     = 1'b0;
                w_addr[10] = 1'b1;
            end
            ST_AREF: begin
                w_ras_n = 1'b0;
                w_cas_n = 1'b0;
            end
            ST_MRS: begin
                w_ras_n     = 1'b0;
                w_cas_n     = 1'b0;
                w_we_n      = 1'b0;
                w_addr[6:4] = cfg_sdr_cas;
                w_addr[2:0] = cfg_sdr_bl;
            end
`ifdef SDR_INIT_EXT_MODE_EN
            ST_EMRS: begin
                w_ras_n = 1'b0;
                w_cas_n = 1'b0;
                w_we_n  = 1'b0;
                w_ba    = 2'b01;
            end
`endif
            ST_DONE: begin
                w_done = 1'b1;
                w_busy = 1'b0;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            r_state    <= ST_IDLE;
            r_pwr_cnt  <= '0;
            r_wait_cnt <= 4'd0;
            r_aref_cnt <= 4'd0;
        end else begin
            r_state <= w_next;

            if (w_next == ST_IDLE)
                r_pwr_cnt <= '0;
            else if (r_state == ST_PWRUP && r_pwr_cnt != PWR_TERM)
                r_pwr_cnt <= r_pwr_cnt + 1'b1;

            if (cfg_sdr_en && w_in_wait && !w_wait_last)
                r_wait_cnt <= r_wait_cnt + 4'd1;
            else
                r_wait_cnt <= 4'd0;

            if (w_next == ST_IDLE)
                r_aref_cnt <= 4'd0;
            else if (r_state == ST_AREF)
                r_aref_cnt <= r_aref_cnt + 4'd1;
        end
    end

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            r_cke   <= 1'b0;
            r_cs_n  <= 1'b1;
            r_ras_n <= 1'b1;
            r_cas_n <= 1'b1;
            r_we_n  <= 1'b1;
            r_ba    <= 2'b00;
            r_addr  <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_cke   <= w_cke;
            r_cs_n  <= w_cs_n;
            r_ras_n <= w_ras_n;
            r_cas_n <= w_cas_n;
            r_we_n  <= w_we_n;
            r_ba    <= w_ba;
            r_addr  <= w_addr;
            r_done  <= w_done;
            r_busy  <= w_busy;
        end
    end

    assign sdr_if.sdr_cke       = r_cke;
    assign sdr_if.sdr_cs_n      = r_cs_n;
    assign sdr_if.sdr_ras_n     = r_ras_n;
    assign sdr_if.sdr_cas_n     = r_cas_n;
    assign sdr_if.sdr_we_n      = r_we_n;
    assign sdr_if.sdr_ba        = r_ba;
    assign sdr_if.sdr_addr      = r_addr;
    assign sdr_if.sdr_init_done = r_done;
    assign sdr_if.init_busy     = r_busy;
endmodule

// File: tb/tb_sdrc_init_seq.sv
// Self-checking bench for sdrc_init_seq: per-cycle compare against a phase-arithmetic model,
// plus literal checks of power-up length, refresh spacing, mode word and reset behaviour.
module tb_sdrc_init_seq;
    localparam int SDR_AW    = 13;
    localparam int PWRUP_CYC = 10000;
    localparam int AREF_NUM  = 2;
    localparam int TRFC_MIN  = 7;
    localparam int LIMIT     = 12000;

    typedef struct packed {
        logic              cke;
        logic              cs_n;
        logic              ras_n;
        logic              cas_n;
        logic              we_n;
        logic [1:0]        ba;
        logic [SDR_AW-1:0] addr;
        logic              done;
        logic              busy;
    } pins_t;

    localparam pins_t RESET_PINS = '{cke: 1'b0, cs_n: 1'b1, ras_n: 1'b1, cas_n: 1'b1,
                                     we_n: 1'b1, ba: 2'b00, addr: '0, done: 1'b0, busy: 1'b0};

    logic       sdram_clk    = 1'b0;
    logic       sdram_resetn = 1'b0;
    logic       cfg_sdr_en   = 1'b0;
    logic [2:0] cfg_sdr_cas  = 3'd0;
    logic [2:0] cfg_sdr_bl   = 3'd0;
    logic [3:0] cfg_sdr_trp_d  = 4'd0;
    logic [3:0] cfg_sdr_trfc_d = 4'd0;
    logic [3:0] cfg_sdr_tmrd_d = 4'd0;

    sdrc_init_seq_if #(.SDR_AW(SDR_AW)) sif ();

    sdrc_init_seq #(
        .SDR_AW(SDR_AW), .PWRUP_CYC(PWRUP_CYC), .AREF_NUM(AREF_NUM), .TRFC_MIN(TRFC_MIN)
    ) dut (
        .sdram_clk      (sdram_clk),
        .sdram_resetn   (sdram_resetn),
        .cfg_sdr_en     (cfg_sdr_en),
        .cfg_sdr_cas    (cfg_sdr_cas),
        .cfg_sdr_bl     (cfg_sdr_bl),
        .cfg_sdr_trp_d  (cfg_sdr_trp_d),
        .cfg_sdr_trfc_d (cfg_sdr_trfc_d),
        .cfg_sdr_tmrd_d (cfg_sdr_tmrd_d),
        .sdr_if         (sif)
    );

    always #5 sdram_clk = ~sdram_clk;

    pins_t dut_pins;
    assign dut_pins = {sif.sdr_cke, sif.sdr_cs_n, sif.sdr_ras_n, sif.sdr_cas_n, sif.sdr_we_n,
                       sif.sdr_ba, sif.sdr_addr, sif.sdr_init_done, sif.init_busy};

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic int trp_eff();
        return (cfg_sdr_trp_d == 4'd0) ? 1 : int'(cfg_sdr_trp_d);
    endfunction
    function automatic int trfc_eff();
        return (int'(cfg_sdr_trfc_d) < TRFC_MIN - 1) ? TRFC_MIN - 1 : int'(cfg_sdr_trfc_d);
    endfunction
    function automatic int tmrd_eff();
        return (cfg_sdr_tmrd_d == 4'd0) ? 1 : int'(cfg_sdr_tmrd_d);
    endfunction

    // Cycle offset of the first DONE cycle relative to the first power-up NOP.
    function automatic int done_offset();
        int off;
        off = PWRUP_CYC + 1 + trp_eff() + AREF_NUM * (1 + trfc_eff()) + 1 + tmrd_eff();
`ifdef SDR_INIT_EXT_MODE_EN
        off = off + 1 + tmrd_eff();
`endif
        return off;
    endfunction

    // Expected pins k cycles after the sequence started, walking the phase list.
    function automatic pins_t model_pins(input bit active, input int k);
        pins_t p;
        p = RESET_PINS;
        if (!active) return p;
        p.cke  = 1'b1;
        p.cs_n = 1'b0;
        p.busy = 1'b1;
        if (k < PWRUP_CYC) return p;
        k -= PWRUP_CYC;
        if (k == 0) begin p.ras_n = 1'b0; p.we_n = 1'b0; p.addr[10] = 1'b1; return p; end
        k -= 1;
        if (k < trp_eff()) return p;
        k -= trp_eff();
        for (int i = 0; i < AREF_NUM; i++) begin
            if (k == 0) begin p.ras_n = 1'b0; p.cas_n = 1'b0; return p; end
            k -= 1;
            if (k < trfc_eff()) return p;
            k -= trfc_eff();
        end
        if (k == 0) begin
            p.ras_n = 1'b0; p.cas_n = 1'b0; p.we_n = 1'b0;
            p.addr[6:4] = cfg_sdr_cas;
            p.addr[2:0] = cfg_sdr_bl;
            return p;
        end
        k -= 1;
        if (k < tmrd_eff()) return p;
        k -= tmrd_eff();
`ifdef SDR_INIT_EXT_MODE_EN
        if (k == 0) begin p.ras_n = 1'b0; p.cas_n = 1'b0; p.we_n = 1'b0; p.ba = 2'b01; return p; end
        k -= 1;
        if (k < tmrd_eff()) return p;
`endif
        p.done = 1'b1;
        p.busy = 1'b0;
        return p;
    endfunction

    bit m_active = 1'b0;
    int m_k      = 0;

    initial forever begin
        @(posedge sdram_clk or negedge sdram_resetn);
        if (!sdram_resetn || !cfg_sdr_en) m_active = 1'b0;
        else if (!m_active) begin m_active = 1'b1; m_k = 0; end
        else m_k++;
    end

    int trace_gen = 0;
    int t_gen = 0;
    int t_idx, first_nop, pre_idx, mrs_idx, emrs_idx, done_idx;
    logic              pre_a10;
    logic [SDR_AW-1:0] mrs_addr, emrs_addr;
    logic [1:0]        mrs_ba, emrs_ba;
    int aref_q[$];

    initial forever begin
        @(negedge sdram_clk);
        check("cycle", 64'(dut_pins), 64'(model_pins(m_active, m_k)));
        if (trace_gen != t_gen) begin
            t_gen = trace_gen;
            t_idx = 0; first_nop = -1; pre_idx = -1; mrs_idx = -1; emrs_idx = -1; done_idx = -1;
            pre_a10 = 1'b0; mrs_addr = '0; emrs_addr = '1; mrs_ba = 2'b11; emrs_ba = 2'b00;
            aref_q.delete();
        end
        if (sif.sdr_cke && first_nop < 0) first_nop = t_idx;
        if (!sif.sdr_cs_n && !sif.sdr_ras_n && sif.sdr_cas_n && !sif.sdr_we_n && pre_idx < 0) begin
            pre_idx = t_idx;
            pre_a10 = sif.sdr_addr[10];
        end
        if (!sif.sdr_cs_n && !sif.sdr_ras_n && !sif.sdr_cas_n && sif.sdr_we_n) aref_q.push_back(t_idx);
        if (!sif.sdr_cs_n && !sif.sdr_ras_n && !sif.sdr_cas_n && !sif.sdr_we_n) begin
            if (sif.sdr_ba == 2'b00 && mrs_idx < 0) begin
                mrs_idx = t_idx; mrs_addr = sif.sdr_addr; mrs_ba = sif.sdr_ba;
            end else if (sif.sdr_ba != 2'b00 && emrs_idx < 0) begin
                emrs_idx = t_idx; emrs_addr = sif.sdr_addr; emrs_ba = sif.sdr_ba;
            end
        end
        if (sif.sdr_init_done && done_idx < 0) done_idx = t_idx;
        t_idx++;
    end

    task automatic wait_done(input string name);
        int n = 0;
        while (sif.sdr_init_done !== 1'b1 && n < LIMIT) begin
            @(negedge sdram_clk);
            n++;
        end
        check(name, 64'(sif.sdr_init_done), 64'd1);
        repeat (3) @(negedge sdram_clk);
    endtask

    task automatic random_cfg();
        cfg_sdr_cas    = 3'($urandom_range(0, 7));
        cfg_sdr_bl     = 3'($urandom_range(0, 7));
        cfg_sdr_trp_d  = 4'($urandom_range(0, 15));
        cfg_sdr_trfc_d = 4'($urandom_range(0, 15));
        cfg_sdr_tmrd_d = 4'($urandom_range(0, 15));
    endtask

    initial begin
        repeat (3) @(negedge sdram_clk);
        check("reset_pins", 64'(dut_pins), 64'(RESET_PINS));
        sdram_resetn = 1'b1;
        repeat (3) @(negedge sdram_clk);
        check("idle_without_en", 64'(dut_pins), 64'(RESET_PINS));

        // Directed run: cas=3, bl=2, trp=3, trfc=2 (floored to 6), tmrd=2.
        cfg_sdr_cas = 3'b011; cfg_sdr_bl = 3'b010;
        cfg_sdr_trp_d = 4'd3; cfg_sdr_trfc_d = 4'd2; cfg_sdr_tmrd_d = 4'd2;
        trace_gen++;
        cfg_sdr_en = 1'b1;
        wait_done("run1_done");
        check("pwrup_nop_count", 64'(pre_idx - first_nop), 64'd10000);
        check("pre_addr10", 64'(pre_a10), 64'd1);
        check("aref_count", 64'(aref_q.size()), 64'd2);
        if (aref_q.size() >= 2) begin
            check("aref0_offset", 64'(aref_q[0] - first_nop), 64'd10004);
            check("aref_spacing", 64'(aref_q[1] - aref_q[0]), 64'd7);
        end
        check("mrs_offset", 64'(mrs_idx - first_nop), 64'd10018);
        check("mrs_addr", 64'(mrs_addr), 64'h0032);
        check("mrs_ba", 64'(mrs_ba), 64'd0);
`ifdef SDR_INIT_EXT_MODE_EN
        check("emrs_after_mrs", 64'(emrs_idx - mrs_idx), 64'd3);
        check("emrs_ba", 64'(emrs_ba), 64'd1);
        check("emrs_addr", 64'(emrs_addr), 64'd0);
        check("done_offset", 64'(done_idx - first_nop), 64'd10024);
`else
        check("done_offset", 64'(done_idx - first_nop), 64'd10021);
`endif

        // Drop enable from DONE, then drop it again in the middle of TRFC.
        cfg_sdr_en = 1'b0;
        @(negedge sdram_clk);
        check("drop_from_done", 64'(dut_pins), 64'(RESET_PINS));
        random_cfg();
        trace_gen++;
        cfg_sdr_en = 1'b1;
        begin
            int n = 0;
            while (aref_q.size() == 0 && n < LIMIT) begin @(negedge sdram_clk); n++; end
            check("aref_seen", 64'(aref_q.size() > 0), 64'd1);
        end
        repeat (2) @(negedge sdram_clk);
        cfg_sdr_en = 1'b0;
        @(negedge sdram_clk);
        check("trfc_drop_cs_n", 64'(sif.sdr_cs_n), 64'd1);
        check("trfc_drop_busy", 64'(sif.init_busy), 64'd0);
        check("trfc_drop_done", 64'(sif.sdr_init_done), 64'd0);
        repeat (3) @(negedge sdram_clk);
        trace_gen++;
        cfg_sdr_en = 1'b1;
        wait_done("run2_done");
        check("rerun_pwrup_count", 64'(pre_idx - first_nop), 64'd10000);
        check("rerun_done_offset", 64'(done_idx - first_nop), 64'(done_offset()));

        // Asynchronous reset in the middle of the power-up wait.
        cfg_sdr_en = 1'b0;
        @(negedge sdram_clk);
        random_cfg();
        cfg_sdr_en = 1'b1;
        repeat (300) @(negedge sdram_clk);
        @(posedge sdram_clk);
        #2 sdram_resetn = 1'b0;
        #1 check("async_reset_pins", 64'(dut_pins), 64'(RESET_PINS));
        @(negedge sdram_clk);
        check("reset_hold_pins", 64'(dut_pins), 64'(RESET_PINS));
        trace_gen++;
        sdram_resetn = 1'b1;
        wait_done("run3_done");
        check("post_reset_pwrup_count", 64'(pre_idx - first_nop), 64'd10000);
        check("post_reset_done_offset", 64'(done_idx - first_nop), 64'(done_offset()));

        // Random enable glitching early in the sequence, then a clean finish.
        cfg_sdr_en = 1'b0;
        @(negedge sdram_clk);
        random_cfg();
        for (int i = 0; i < 200; i++) begin
            cfg_sdr_en = ($urandom_range(0, 9) != 0);
            @(negedge sdram_clk);
        end
        cfg_sdr_en = 1'b1;
        wait_done("run4_done");
        repeat (5) @(negedge sdram_clk);
        cfg_sdr_en = 1'b0;
        repeat (2) @(negedge sdram_clk);
        check("final_idle", 64'(dut_pins), 64'(RESET_PINS));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
